// File: rtl/bus_slave_port.sv
// bus_slave_port: bit-serial system-bus responder.
// Takes a serial header (address, burst length) from the granted master.
// Writes store into a local word memory. Reads stream back LSB first.
// A read can optionally release the bus (split) and re-request it later.
module bus_slave_port #(
    parameter int ADDR_WIDTH     = 12,
    parameter int MEM_ADDR_WIDTH = 6,
    parameter int DATA_WIDTH     = 8,
    parameter int BURST_WIDTH    = 4,
    parameter int READ_LATENCY   = 0
) (
    input  logic clock,
    input  logic rst,
    input  logic s_select,
    input  logic m_valid,
    input  logic m_data,
    input  logic m_rw,
    output logic s_ready,
    output logic s_valid,
    output logic s_data,
    output logic s_split,
    output logic split_req,
    input  logic split_grant,
    output logic busy
);

    localparam int DEPTH  = 1 << MEM_ADDR_WIDTH;
    localparam int CNT_W  = $clog2(ADDR_WIDTH + DATA_WIDTH + BURST_WIDTH + 1);
    localparam int WAIT_W = $clog2(READ_LATENCY + 2);

    typedef enum logic [3:0] {
        IDLE,
        RX_ADDR,
        RX_LEN,
        RX_WDATA,
        WR_MEM,
        SPLIT,
        RD_WAIT,
        SPLIT_REQ,
        RD_FETCH,
        TX_RDATA
    } state_t;

    state_t                    state;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [BURST_WIDTH-1:0]    words_left;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [CNT_W-1:0]          bit_cnt;
    logic [WAIT_W-1:0]         wait_cnt;
    logic                      rw_q;
    logic [MEM_ADDR_WIDTH-1:0] mem_ptr;
    logic [MEM_ADDR_WIDTH-1:0] next_ptr;
    logic [DATA_WIDTH-1:0]     mem [DEPTH];

    // Only the low address bits index the memory, and the pointer wraps
    // around the memory depth.
    assign mem_ptr  = addr_q[MEM_ADDR_WIDTH-1:0];
    assign next_ptr = mem_ptr + MEM_ADDR_WIDTH'(1);

    assign s_ready = (state == IDLE);
    assign busy    = ~s_ready;
    assign s_data  = s_valid & data_q[0];

    // Transaction sequencer: header reception, write/read data movement, split handshake
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            words_left <= '0;
            data_q     <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            rw_q       <= 1'b0;
            s_valid    <= 1'b0;
            s_split    <= 1'b0;
            split_req  <= 1'b0;
        end else begin
            s_split <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_select && m_valid) begin
                        addr_q  <= {m_data, addr_q[ADDR_WIDTH-1:1]};
                        rw_q    <= m_rw;
                        bit_cnt <= CNT_W'(1);
                        state   <= RX_ADDR;
                    end
                end
                RX_ADDR: begin
                    if (!s_select) begin
                        state <= IDLE;
                    end else if (m_valid) begin
                        addr_q <= {m_data, addr_q[ADDR_WIDTH-1:1]};
                        if (bit_cnt == CNT_W'(ADDR_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            state   <= RX_LEN;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                RX_LEN: begin
                    if (!s_select) begin
                        state <= IDLE;
                    end else if (m_valid) begin
                        words_left <= {m_data, words_left[BURST_WIDTH-1:1]};
                        if (bit_cnt == CNT_W'(BURST_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            if (!rw_q) begin
                                state <= RX_WDATA;
                            end else if (READ_LATENCY == 0) begin
                                state <= RD_FETCH;
                            end else begin
                                state   <= SPLIT;
                                s_split <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                RX_WDATA: begin
                    if (!s_select) begin
                        state <= IDLE;
                    end else if (m_valid) begin
                        data_q <= {m_data, data_q[DATA_WIDTH-1:1]};
                        if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            state   <= WR_MEM;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                WR_MEM: begin
                    addr_q[MEM_ADDR_WIDTH-1:0] <= next_ptr;
                    if (words_left == '0) begin
                        state <= IDLE;
                    end else begin
                        words_left <= words_left - BURST_WIDTH'(1);
                        state      <= RX_WDATA;
                    end
                end
                SPLIT: begin
                    wait_cnt <= '0;
                    state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (wait_cnt == WAIT_W'(READ_LATENCY - 1)) begin
                        split_req <= 1'b1;
                        state     <= SPLIT_REQ;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                SPLIT_REQ: begin
                    if (split_grant) begin
                        split_req <= 1'b0;
                        state     <= RD_FETCH;
                    end
                end
                RD_FETCH: begin
                    data_q  <= mem[mem_ptr];
                    bit_cnt <= '0;
                    s_valid <= 1'b1;
                    state   <= TX_RDATA;
                end
                TX_RDATA: begin
                    if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt <= '0;
                        if (words_left == '0) begin
                            s_valid <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            data_q                     <= mem[next_ptr];
                            addr_q[MEM_ADDR_WIDTH-1:0] <= next_ptr;
                            words_left                 <= words_left - BURST_WIDTH'(1);
                        end
                    end else begin
                        data_q  <= {1'b0, data_q[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Commit a fully received word; memory keeps its contents across reset
    always_ff @(posedge clock) begin
        if (state == WR_MEM) begin
            mem[mem_ptr] <= data_q;
        end
    end

endmodule

// File: doc/bus_slave_port.md
Name: bus_slave_port

Overview:
- Serial system-bus responder (slave end): the counterpart of the bus master initiator.
- Receives a bit-serial header (address, burst length) from the granted master, then either accepts write data into a local word memory or returns read data bit-serially.
- Supports burst transfers.
- Optionally releases the bus during a long read (split) and re-requests it from the arbiter once the data is ready.

Parameters:
- ADDR_WIDTH, 12, address bits in the header.
- MEM_ADDR_WIDTH, 6, low address bits that index the local memory (depth 2**MEM_ADDR_WIDTH).
- DATA_WIDTH, 8, bits per data word.
- BURST_WIDTH, 4, burst-length field bits.
- READ_LATENCY, 0, wait cycles before read data is available; 0 disables split.

Ports:
- clock  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- s_select  in  1  address decoder selects this slave for the current transaction.
- m_valid  in  1  m_data bit valid this cycle.
- m_data  in  1  serial bit from master, LSB first.
- m_rw  in  1  1 = read, 0 = write; sampled with the first header bit.
- s_ready  out  1  slave idle, may accept a header.
- s_valid  out  1  s_data bit valid this cycle.
- s_data  out  1  serial read data to master, LSB first.
- s_split  out  1  one-cycle pulse: slave releases the bus (split).
- split_req  out  1  request to the arbiter to resume a split transaction.
- split_grant  in  1  arbiter grant for split_req.
- busy  out  1  high in every state except IDLE.

Behaviour:
- **Reset (rst=0, async):**
  - State IDLE; all counters and shift registers cleared.
  - s_valid=0, s_data=0, s_split=0, split_req=0, busy=0, s_ready=1.
  - Memory contents are not reset.
  - Reset mid-operation aborts immediately; a partial word is never written.
- **Outputs:** s_ready = (state==IDLE); busy = !s_ready.
- **States:** IDLE, RX_ADDR, RX_LEN, RX_WDATA, WR_MEM, SPLIT, RD_WAIT, SPLIT_REQ, RD_FETCH, TX_RDATA.
- **Receiving bits:** one bit is consumed per cycle with m_valid=1; m_valid=0 stalls with no state change (gaps allowed in all RX states).
- **IDLE → RX_ADDR:** on s_select && m_valid. That edge stores address bit 0 and latches m_rw.
- **RX_ADDR → RX_LEN:** after ADDR_WIDTH bits.
- **RX_LEN:** collects BURST_WIDTH bits as field L. Word count = L+1 (L=0 is a single word).
  - Write: go to RX_WDATA.
  - Read with READ_LATENCY=0: go to RD_FETCH.
  - Read with READ_LATENCY>0: go to SPLIT.
- **RX_WDATA:** shifts DATA_WIDTH bits.
  - On the last bit of a word: WR_MEM.
  - WR_MEM writes mem[addr[MEM_ADDR_WIDTH-1:0]] next edge, increments addr, decrements the word count.
  - If words remain, return to RX_WDATA; otherwise IDLE.
- **Address increment:** modulo 2**MEM_ADDR_WIDTH (wraps).
- **s_select low in RX_ADDR/RX_LEN/RX_WDATA:** abort to IDLE next edge. Words already committed stay written; the partial word is discarded.
- **SPLIT:** s_split=1 for exactly one cycle, then RD_WAIT.
- **RD_WAIT:** counts READ_LATENCY cycles, then SPLIT_REQ.
- **SPLIT_REQ:** split_req=1 held until split_grant is sampled 1, then RD_FETCH; split_req drops in the same edge.
- **s_select in SPLIT/RD_WAIT/SPLIT_REQ/RD_FETCH/TX_RDATA:** ignored.
- **RD_FETCH (1 cycle):** loads the shift register from mem[addr].
- **TX_RDATA:**
  - s_valid=1 and s_data=current LSB every cycle; no stall.
  - Words are sent back-to-back: the next word's load occurs in the same edge as the previous word's last bit, with no gap.
  - After (L+1)*DATA_WIDTH bits: IDLE; s_valid=0 in the first IDLE cycle.
- **Latencies:**
  - Write: s_ready returns 2 cycles after the edge sampling the final data bit.
  - Non-split read: first s_valid 2 cycles after the edge sampling the last length bit.
  - Split read: first s_valid 2 cycles after the edge sampling split_grant=1.
- **Simultaneous events:** split_grant while not in SPLIT_REQ is ignored; m_valid outside RX states is ignored.

Test Plan:
1. Write addr 0x00A, L=0, data 0xA5; then read addr 0x00A, L=0 -> s_valid high 8 consecutive cycles, s_data 1,0,1,0,0,1,0,1; s_split never asserts.
2. Burst write addr 0x010, L=3, data 0x11,0x22,0x33,0x44; burst read same -> 32 contiguous s_valid cycles reproducing the words in order; s_ready=1 2 cycles after each transaction ends.
3. READ_LATENCY=4, read L=1 -> s_split single pulse after the last length bit; 4 RD_WAIT cycles; split_req held with split_grant low for 10 cycles; s_valid starts 2 cycles after grant; 16 bits out.
4. MEM_ADDR_WIDTH=4, write addr 0x00F, L=1, data 0x5A,0xC3 -> mem[15]=0x5A, mem[0]=0xC3 (wrap); read back 0x00F, L=1 returns 0x5A then 0xC3.
5. Write with m_valid toggling 1/0 every cycle -> same memory result as gap-free. Write L=1 with s_select dropped after 4 bits of word 2 -> word 1 written, word 2 untouched, s_ready=1 next cycle.
6. Assert rst=0 mid-TX_RDATA -> s_valid=0, split_req=0, busy=0, s_ready=1 immediately (asynchronous); next transaction after release completes correctly.
